// File: rtl/pcxt_spi_pkg.sv
// rtl/pcxt_spi_pkg.sv - shared types and constants for the SPI host master
package pcxt_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_CHAIN,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    localparam logic [1:0] SS_IDX_SS2 = 2'd0;
    localparam logic [1:0] SS_IDX_SS3 = 2'd1;
    localparam logic [1:0] SS_IDX_SS4 = 2'd2;

    localparam int BITS_PER_BYTE = 8;

    // Active-low one-hot select pattern {SS4,SS3,SS2}.
    function automatic logic [2:0] ss_decode_n(input logic [1:0] idx);
        case (idx)
            SS_IDX_SS3: ss_decode_n = 3'b101;
            SS_IDX_SS4: ss_decode_n = 3'b011;
            default:    ss_decode_n = 3'b110;
        endcase
    endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// rtl/spi_clk_tick.sv - SCK half-period timer, single-cycle tick every CLK_DIV cycles
module spi_clk_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == 8'(CLK_DIV - 1));
        cnt_d = cnt_q + 8'd1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// rtl/spi_host_master.sv - mode-0 MSB-first SPI initiator with chained bytes on one select
module spi_host_master
    import pcxt_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_data,
    input  logic [1:0] req_ss,
    input  logic       req_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [2:0] spi_ss_n
);

    spi_state_t state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       last_q, last_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       done_q, done_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       busy_q, busy_d;
    logic [2:0] ss_n_q, ss_n_d;
    logic [1:0] req_idx;
    logic       take;
    logic       tick;
    logic       restart;

    assign req_idx = (req_ss == 2'd3) ? SS_IDX_SS2 : req_ss;
    assign restart = (state_d != state_q);

    spi_clk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        bit_cnt_d   = bit_cnt_q;
        done_d      = done_q;
        gap_cnt_d   = gap_cnt_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        ss_n_d      = ss_n_q;
        rsp_valid_d = 1'b0;
        take        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    take    = 1'b1;
                    sel_d   = req_idx;
                    ss_n_d  = ss_decode_n(req_idx);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[6:0], spi_miso};
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A tick with SCK low either rises or, after the 8th fall, closes the byte.
                if (tick) begin
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bit_cnt_q == 3'(BITS_PER_BYTE - 1)) begin
                            done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            tx_d      = {tx_q[6:0], 1'b0};
                            mosi_d    = tx_q[6];
                        end
                    end else if (done_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rx_q;
                        state_d     = last_q ? ST_HOLD : ST_CHAIN;
                    end else begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], spi_miso};
                    end
                end
            end
            ST_CHAIN: begin
                if (req_valid && ready_q) begin
                    if (req_idx == sel_q) begin
                        take    = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    ss_n_d    = 3'b111;
                    mosi_d    = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_q == 8'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            tx_d      = req_data;
            last_d    = req_last;
            mosi_d    = req_data[7];
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end

        ready_d = (state_d == ST_IDLE) || (state_d == ST_CHAIN);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= SS_IDX_SS2;
            last_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
            gap_cnt_q   <= '0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ss_n_q      <= 3'b111;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= done_d;
            gap_cnt_q   <= gap_cnt_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            ss_n_q      <= ss_n_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign spi_ss_n  = ss_n_q;

endmodule

// File: tb/tb_spi_host_master.sv
// tb/tb_spi_host_master.sv - randomized self-checking bench for spi_host_master
module tb_spi_host_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, req_valid, req_last, use1, use_model;
    logic [7:0] req_data;
    logic [1:0] req_ss;

    logic       rdy0, rv0, busy0, sck0, mosi0, miso0;
    logic [7:0] rd0;
    logic [2:0] ss0;
    logic       rdy1, rv1, busy1, sck1, mosi1, miso1;
    logic [7:0] rd1;
    logic [2:0] ss1;

    logic       req_ready, rsp_valid, busy, sck, mosi, model_bit;
    logic [7:0] rsp_data;
    logic [2:0] ss_n;

    assign req_ready = use1 ? rdy1 : rdy0;
    assign rsp_valid = use1 ? rv1 : rv0;
    assign rsp_data  = use1 ? rd1 : rd0;
    assign busy      = use1 ? busy1 : busy0;
    assign sck       = use1 ? sck1 : sck0;
    assign mosi      = use1 ? mosi1 : mosi0;
    assign ss_n      = use1 ? ss1 : ss0;
    assign miso0     = use_model ? model_bit : mosi0;
    assign miso1     = use_model ? model_bit : mosi1;

    spi_host_master #(.CLK_DIV(2), .GAP_CYC(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid & ~use1), .req_ready(rdy0),
        .req_data(req_data), .req_ss(req_ss), .req_last(req_last), .rsp_valid(rv0),
        .rsp_data(rd0), .busy(busy0), .spi_sck(sck0), .spi_mosi(mosi0),
        .spi_miso(miso0), .spi_ss_n(ss0)
    );

    spi_host_master #(.CLK_DIV(1), .GAP_CYC(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid & use1), .req_ready(rdy1),
        .req_data(req_data), .req_ss(req_ss), .req_last(req_last), .rsp_valid(rv1),
        .rsp_data(rd1), .busy(busy1), .spi_sck(sck1), .spi_mosi(mosi1),
        .spi_miso(miso1), .spi_ss_n(ss1)
    );

    int checks = 0, errors = 0, cyc = 0;
    int rises, deasserts, gap_run, hi_run, last_hi_run, ready_in_gap, bad_ss, bad_sck;
    int idle_cyc, acc_cyc;
    logic [2:0] seen_sel, prev_ss;
    logic       prev_sck, prev_busy;
    logic [7:0] obs_d[$], exp_d[$], slave_q[$];
    int         obs_c[$], exp_c[$];
    bit         chain_open;
    logic [1:0] chain_ss;
    logic [7:0] s_byte;
    int         s_bit;

    function automatic int cd();
        return use1 ? 1 : 2;
    endfunction

    function automatic int gapc();
        return use1 ? 3 : 2;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Mode-0 slave: bit 7 valid at select, next bit after each SCK fall, new byte every 8 falls.
    assign model_bit = s_byte[3'(7 - s_bit)];
    initial begin
        logic was_hi, last_sck;
        was_hi = 1'b1; last_sck = 1'b0; s_bit = 0; s_byte = 8'h00;
        forever begin
            @(sck or ss_n);
            if (was_hi && ss_n != 3'b111) begin
                s_bit = 0;
                if (slave_q.size() > 0) s_byte = slave_q.pop_front();
            end else if (last_sck && !sck) begin
                s_bit = s_bit + 1;
                if (s_bit == 8) begin
                    s_bit = 0;
                    if (slave_q.size() > 0) s_byte = slave_q.pop_front();
                end
            end
            was_hi = (ss_n == 3'b111);
            last_sck = sck;
        end
    end

    initial begin
        prev_sck = 1'b0; prev_ss = 3'b111; prev_busy = 1'b0;
        bad_ss = 0; bad_sck = 0; hi_run = 0; last_hi_run = 0; idle_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (sck && !prev_sck) rises++;
                if (!(ss_n inside {3'b111, 3'b110, 3'b101, 3'b011})) bad_ss++;
                if (sck && ss_n == 3'b111) bad_sck++;
                seen_sel = seen_sel | ~ss_n;
                if (ss_n == 3'b111) begin
                    hi_run++;
                    if (prev_ss != 3'b111) deasserts++;
                end else begin
                    if (prev_ss == 3'b111) last_hi_run = hi_run;
                    hi_run = 0;
                end
                if (busy && ss_n == 3'b111) begin
                    gap_run++;
                    if (req_ready) ready_in_gap++;
                end
                if (!busy && prev_busy) idle_cyc = cyc;
                if (rsp_valid) begin
                    obs_d.push_back(rsp_data);
                    obs_c.push_back(cyc);
                end
            end
            prev_sck = sck; prev_ss = ss_n; prev_busy = busy;
        end
    end

    task automatic clear_stats();
        rises = 0; deasserts = 0; gap_run = 0; ready_in_gap = 0; seen_sel = 3'b000;
        obs_d.delete(); obs_c.delete(); exp_d.delete(); exp_c.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] ss, input logic last,
                        input logic [7:0] exp);
        logic [1:0] idx;
        logic rdy, mism, done;
        idx = (ss == 2'd3) ? 2'd0 : ss;
        done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_data = d; req_ss = ss; req_last = last;
        for (int k = 0; k < 400 && !done; k++) begin
            rdy = req_ready;
            mism = chain_open && (idx != chain_ss);
            @(posedge clk);
            #1;
            if (rdy && !mism) begin
                done = 1'b1;
                acc_cyc = cyc;
                exp_d.push_back(exp);
                exp_c.push_back(cyc + 17 * cd());
            end else if (rdy && mism) begin
                chain_open = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("accept", 32'(done), 1);
        chain_open = !last;
        chain_ss = idx;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(negedge clk);
            ok = !busy;
        end
        @(negedge clk);
        check("idle", 32'(ok), 1);
    endtask

    task automatic check_rsp(input string tag);
        check({tag, "_count"}, obs_d.size(), exp_d.size());
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            check({tag, "_data"}, 32'(obs_d[i]), 32'(exp_d[i]));
            check({tag, "_cyc"}, obs_c[i], exp_c[i]);
        end
    endtask

    initial begin
        logic [7:0] d1, d2;
        logic       ok;
        reset_n = 1'b0; req_valid = 1'b0; req_data = '0; req_ss = '0; req_last = 1'b0;
        use1 = 1'b0; use_model = 1'b0; chain_open = 1'b0; chain_ss = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(ss_n), 32'h7);
        check("rst_sck", 32'(sck), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 1);

        // single byte, loopback
        clear_stats();
        send(8'hA5, 2'd0, 1'b1, 8'hA5);
        check("t1_ss_n", 32'(ss_n), 32'h6);
        check("t1_mosi", 32'(mosi), 1);
        wait_idle();
        check_rsp("t1");
        check("t1_rises", rises, 8);
        check("t1_sel", 32'(seen_sel), 32'h1);
        check("t1_gap", gap_run, gapc());
        check("t1_deassert", deasserts, 1);

        // three-byte chain on SS3 against the slave model
        clear_stats();
        use_model = 1'b1;
        slave_q = '{8'h3C, 8'h81, 8'h7E};
        send(8'h14, 2'd1, 1'b0, 8'h3C);
        send(8'h00, 2'd1, 1'b0, 8'h81);
        send(8'hFF, 2'd1, 1'b1, 8'h7E);
        wait_idle();
        use_model = 1'b0;
        check_rsp("t2");
        check("t2_rises", rises, 24);
        check("t2_sel", 32'(seen_sel), 32'h2);
        check("t2_deassert", deasserts, 1);

        // select switch inside an open chain
        clear_stats();
        d1 = 8'($urandom); d2 = 8'($urandom);
        send(d1, 2'd0, 1'b0, d1);
        send(d2, 2'd2, 1'b1, d2);
        wait_idle();
        check_rsp("t3");
        check("t3_sel", 32'(seen_sel), 32'h5);
        check("t3_gap_min", 32'(last_hi_run >= gapc()), 1);
        check("t3_deassert", deasserts, 2);
        check("t3_rises", rises, 16);

        // reset in the middle of a byte
        clear_stats();
        d1 = 8'($urandom);
        send(d1, 2'd0, 1'b1, d1);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = (rises >= 3);
        end
        check("t4_reach3", 32'(ok), 1);
        reset_n = 1'b0;
        #1;
        check("t4_ss_n", 32'(ss_n), 32'h7);
        check("t4_sck", 32'(sck), 0);
        check("t4_rsp_valid", 32'(rsp_valid), 0);
        check("t4_no_rsp", obs_d.size(), 0);
        chain_open = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_stats();
        send(8'h5A, 2'd0, 1'b1, 8'h5A);
        wait_idle();
        check_rsp("t4");
        check("t4_rises", rises, 8);

        // CLK_DIV=1 instance: ss=3 maps to SS2, request held through GAP
        use1 = 1'b1;
        repeat (2) @(negedge clk);
        clear_stats();
        d1 = 8'($urandom); d2 = 8'($urandom);
        send(d1, 2'd3, 1'b1, d1);
        check("t5_ss3_is_ss2", 32'(ss_n), 32'h6);
        send(d2, 2'd1, 1'b1, d2);
        check("t5_first_idle", acc_cyc, idle_cyc + 1);
        check("t5_gap", gap_run, gapc());
        wait_idle();
        check_rsp("t5");
        check("t5_ready_in_gap", ready_in_gap, 0);
        check("t5_sel", 32'(seen_sel), 32'h3);

        // randomized traffic on both instances
        for (int p = 0; p < 2; p++) begin
            use1 = p[0];
            repeat (2) @(negedge clk);
            clear_stats();
            for (int i = 0; i < 8; i++) begin
                d1 = 8'($urandom);
                send(d1, 2'($urandom_range(0, 3)),
                     (i == 7) ? 1'b1 : 1'($urandom_range(0, 1)), d1);
            end
            wait_idle();
            check_rsp(p == 0 ? "rnd0" : "rnd1");
            check("rnd_rises", rises, 64);
        end

        check("one_hot_ss", bad_ss, 0);
        check("sck_without_ss", bad_sck, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
